// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for EX with stall-request handshake.
// Optional DIV_ZERO_FAST_EN: divide-by-zero bypasses the loop and returns zero.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        div_start,
  input  logic        signed_div,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        stallreq_for_ex
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic        signed_q, signed_d;
  logic        dvdNeg_q, dvdNeg_d;
  logic        dvsNeg_q, dvsNeg_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;

  logic        stallReq;
  logic [32:0] partialRem;
  logic [32:0] trialSub;
  logic [31:0] quotNext;
  logic [31:0] remNext;
  logic [31:0] quotFix;
  logic [31:0] remFix;
  logic        unusedStall;

  // Only the MEM freeze bit matters here: it decides whether a result can leave EX.
  assign unusedStall = ^{stall[5], stall[3:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      signed_q <= 1'b0;
      dvdNeg_q <= 1'b0;
      dvsNeg_q <= 1'b0;
      quot_q   <= 32'h0;
      rem_q    <= 32'h0;
      dvs_q    <= 32'h0;
      cnt_q    <= 6'd0;
      result_q <= 64'h0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      dvdNeg_q <= dvdNeg_d;
      dvsNeg_q <= dvsNeg_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // The dividend magnitude shifts out of quot_q MSB-first while quotient bits shift in.
  always_comb begin
    partialRem = {rem_q, quot_q[31]};
    trialSub   = partialRem - {1'b0, dvs_q};
    if (trialSub[32]) begin
      quotNext = {quot_q[30:0], 1'b0};
      remNext  = partialRem[31:0];
    end else begin
      quotNext = {quot_q[30:0], 1'b1};
      remNext  = trialSub[31:0];
    end
    quotFix = (signed_q && (dvdNeg_q ^ dvsNeg_q)) ? (32'h0 - quotNext) : quotNext;
    remFix  = (signed_q && dvdNeg_q) ? (32'h0 - remNext) : remNext;
  end

  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    dvdNeg_d = dvdNeg_q;
    dvsNeg_d = dvsNeg_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    stallReq = 1'b0;

    case (state_q)
      IDLE: begin
        if (div_start && !annul) begin
          stallReq = 1'b1;
          signed_d = signed_div;
          dvdNeg_d = signed_div & dividend[31];
          dvsNeg_d = signed_div & divisor[31];
          quot_d   = (signed_div && dividend[31]) ? (32'h0 - dividend) : dividend;
          dvs_d    = (signed_div && divisor[31]) ? (32'h0 - divisor) : divisor;
          rem_d    = 32'h0;
          cnt_d    = 6'd0;
`ifdef DIV_ZERO_FAST_EN
          if (divisor == 32'h0) begin
            state_d  = DONE;
            result_d = 64'h0;
          end else begin
            state_d = BUSY;
          end
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        stallReq = 1'b1;
        quot_d   = quotNext;
        rem_d    = remNext;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d  = DONE;
          result_d = {remFix, quotFix};
        end
      end
      DONE: begin
        if (!stall[4]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush abandons whatever is in flight and never publishes a result.
    if (annul) begin
      state_d  = IDLE;
      result_d = result_q;
      stallReq = 1'b0;
    end
  end

  assign result          = result_q;
  assign ready           = (state_q == DONE);
  assign stallreq_for_ex = stallReq & ~rst;

endmodule
